// File: rtl/uart_rx_fifo.sv
// Oversampled UART receiver with parity/framing/overrun detection and a receive FIFO.
// Register reads are served over the tri-stated SPART databus.
module uart_rx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    input  logic       RxD,
    inout  wire  [7:0] databus,
    output logic       rda,
    output logic       frame_err,
    output logic       overrun
);
    // state    | meaning
    // S_IDLE   | line idle, waiting for a falling edge
    // S_START  | validating the start bit at mid-bit
    // S_DATA   | shifting in data bits, LSB first
    // S_PARITY | sampling the parity bit
    // S_STOP   | sampling the stop bit, then push or flag an error
    // S_BREAK  | line held low after a framing error, wait for idle
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] TICK_BIT = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0]    LAST_BIT = 4'(DATA_BITS - 1);

    state_t                 state_q, state_d;
    logic                   rx_meta_q, rx_s_q;
    logic [TW-1:0]          tick_q, tick_d;
    logic [3:0]             bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_pend_q, par_pend_d;
    logic                   frame_err_q, parity_err_q, overrun_q;
    logic [AW:0]            wr_ptr_q, rd_ptr_q;
    logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];

    logic push_req, fe_set, pe_set, tick_end;
    logic empty, full, data_rd, stat_rd, pop, push, ov_set;
    logic [7:0] head8, status;

    always_comb begin
        state_d    = state_q;
        tick_d     = enable ? tick_q + 1'b1 : tick_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        par_pend_d = par_pend_q;
        push_req   = 1'b0;
        fe_set     = 1'b0;
        pe_set     = 1'b0;
        tick_end   = enable && (tick_q == TICK_BIT);
        case (state_q)
            S_IDLE: begin
                tick_d     = '0;
                bit_d      = '0;
                par_pend_d = 1'b0;
                if (!rx_s_q) state_d = S_START;
            end
            S_START: begin
                if (enable && (tick_q == TICK_MID)) begin
                    tick_d  = '0;
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (tick_end) begin
                    tick_d  = '0;
                    shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == LAST_BIT) state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (tick_end) begin
                    tick_d = '0;
                    if (rx_s_q != ((^shift_q) ^ (PARITY_ODD != 0))) par_pend_d = 1'b1;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (tick_end) begin
                    tick_d = '0;
                    if (!rx_s_q) begin
                        fe_set  = 1'b1;
                        state_d = S_BREAK;
                    end else if (par_pend_q) begin
                        pe_set  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        push_req = 1'b1;
                        state_d  = S_IDLE;
                    end
                end
            end
            S_BREAK: begin
                tick_d = '0;
                if (rx_s_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            state_q    <= S_IDLE;
            tick_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            par_pend_q <= 1'b0;
        end else begin
            rx_meta_q  <= RxD;
            rx_s_q     <= rx_meta_q;
            state_q    <= state_d;
            tick_q     <= tick_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            par_pend_q <= par_pend_d;
        end
    end

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign data_rd = iocs && iorw && (ioaddr == 2'b00);
    assign stat_rd = iocs && iorw && (ioaddr == 2'b01);
    assign pop     = data_rd && !empty;
    // A same-cycle pop frees the slot the push needs when full.
    assign push    = push_req && (!full || pop);
    assign ov_set  = push_req && full && !pop;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q[AW-1:0]] <= shift_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            frame_err_q  <= fe_set | (frame_err_q  & ~stat_rd);
            parity_err_q <= pe_set | (parity_err_q & ~stat_rd);
            overrun_q    <= ov_set | (overrun_q    & ~stat_rd);
        end
    end

    always_comb begin
        head8 = '0;
        if (!empty) head8[DATA_BITS-1:0] = mem[rd_ptr_q[AW-1:0]];
    end

    assign status    = {3'b000, overrun_q, parity_err_q, frame_err_q, full, !empty};
    assign databus   = data_rd ? head8 : (stat_rd ? status : 8'bzzzz_zzzz);
    assign rda       = !empty;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: one default instance and one even-parity instance,
// checked against a queue-based model of the received characters and sticky flags.
module tb_uart_rx_fifo;
    localparam int BIT_CYC = 64;   // 16 enable ticks, one tick every 4 clocks
    localparam int DEPTH   = 4;

    logic       clk, rst, enable;
    logic [1:0] rxd_v, cs_v, rw_v;
    logic [3:0] addr_v;
    wire  [7:0] db0, db1;
    wire        rda0, fe0, ov0, rda1, fe1, ov1;

    int checks = 0;
    int failures = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [1:0] m_fe, m_ov, m_pe, chk_en;

    uart_rx_fifo u_dut (
        .clk(clk), .rst(rst), .enable(enable), .iocs(cs_v[0]), .iorw(rw_v[0]),
        .ioaddr(addr_v[1:0]), .RxD(rxd_v[0]), .databus(db0),
        .rda(rda0), .frame_err(fe0), .overrun(ov0)
    );

    uart_rx_fifo #(.PARITY_EN(1), .PARITY_ODD(0)) u_par (
        .clk(clk), .rst(rst), .enable(enable), .iocs(cs_v[1]), .iorw(rw_v[1]),
        .ioaddr(addr_v[3:2]), .RxD(rxd_v[1]), .databus(db1),
        .rda(rda1), .frame_err(fe1), .overrun(ov1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        enable = 1'b0;
        forever begin
            repeat (3) @(posedge clk);
            #1 enable = 1'b1;
            @(posedge clk);
            #1 enable = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%02h expected=0x%02h", name, act, exp);
        end
    endtask

    function automatic int m_size(input int idx);
        return (idx == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [7:0] m_head(input int idx);
        if (m_size(idx) == 0) return 8'h00;
        return (idx == 0) ? q0[0] : q1[0];
    endfunction

    function automatic logic [7:0] m_status(input int idx);
        return {3'b000, m_ov[idx], m_pe[idx], m_fe[idx], m_size(idx) == DEPTH, m_size(idx) != 0};
    endfunction

    task automatic model_frame(input int idx, input logic [7:0] data, input logic stop_ok,
                               input logic par_ok);
        if (!stop_ok)                 m_fe[idx] = 1'b1;
        else if (!par_ok)             m_pe[idx] = 1'b1;
        else if (m_size(idx) == DEPTH) m_ov[idx] = 1'b1;
        else if (idx == 0)            q0.push_back(data);
        else                          q1.push_back(data);
    endtask

    task automatic drive_bit(input int idx, input logic b);
        rxd_v[idx] = b;
        repeat (BIT_CYC) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int idx, input logic [7:0] data, input logic par_bit,
                              input logic stop_bit, input int extra_low);
        chk_en[idx] = 1'b0;
        drive_bit(idx, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(idx, data[i]);
        if (idx == 1) drive_bit(idx, par_bit);
        drive_bit(idx, stop_bit);
        for (int i = 0; i < extra_low; i++) drive_bit(idx, 1'b0);
        rxd_v[idx] = 1'b1;
        repeat (16) @(posedge clk);
        #1;
        model_frame(idx, data, stop_bit, (idx == 0) ? 1'b1 : (par_bit == ^data));
        chk_en[idx] = 1'b1;
    endtask

    task automatic bus_read(input int idx, input logic [1:0] addr, input logic [7:0] exp,
                            input string name);
        logic [7:0] m;
        logic [7:0] d;
        cs_v[idx] = 1'b1;
        rw_v[idx] = 1'b1;
        addr_v[2*idx +: 2] = addr;
        m = (addr == 2'b00) ? m_head(idx) : m_status(idx);
        @(negedge clk);
        d = (idx == 0) ? db0 : db1;
        chk({name, "_lit"}, d, exp);
        chk({name, "_model"}, d, m);
        @(posedge clk);
        #1;
        cs_v[idx] = 1'b0;
        rw_v[idx] = 1'b0;
        addr_v[2*idx +: 2] = 2'b00;
        if (addr == 2'b00 && m_size(idx) != 0) begin
            if (idx == 0) void'(q0.pop_front());
            else          void'(q1.pop_front());
        end
        if (addr == 2'b01) begin
            m_fe[idx] = 1'b0;
            m_pe[idx] = 1'b0;
            m_ov[idx] = 1'b0;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (chk_en[0]) begin
                    chk("rda0", 8'(rda0), 8'(m_size(0) != 0));
                    chk("frame_err0", 8'(fe0), 8'(m_fe[0]));
                    chk("overrun0", 8'(ov0), 8'(m_ov[0]));
                end
                if (chk_en[1]) begin
                    chk("rda1", 8'(rda1), 8'(m_size(1) != 0));
                    chk("frame_err1", 8'(fe1), 8'(m_fe[1]));
                    chk("overrun1", 8'(ov1), 8'(m_ov[1]));
                end
            end
        end
    end

    initial begin
        #400000;
        failures++;
        $display("FAIL watchdog simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int cyc;
        rst = 1'b1;
        rxd_v = 2'b11;
        cs_v = 2'b00;
        rw_v = 2'b00;
        addr_v = 4'h0;
        chk_en = 2'b00;
        m_fe = 2'b00;
        m_ov = 2'b00;
        m_pe = 2'b00;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("reset_rda0", 8'(rda0), 8'h00);
        chk("reset_fe0", 8'(fe0), 8'h00);
        chk("reset_ov0", 8'(ov0), 8'h00);
        chk("reset_rda1", 8'(rda1), 8'h00);
        @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 2'b11;
        repeat (4) @(posedge clk);
        #1;
        bus_read(0, 2'b01, 8'h00, "reset_status0");
        bus_read(1, 2'b01, 8'h00, "reset_status1");

        // Single character with latency to rda
        cyc = 0;
        fork
            send_frame(0, 8'hA5, 1'b0, 1'b1, 0);
            begin
                while (!rda0 && cyc < 2000) begin
                    @(negedge clk);
                    cyc++;
                end
            end
        join
        checks++;
        if (cyc < 580 || cyc > 640) begin
            failures++;
            $display("FAIL a5_latency cycles=%0d expected=580..640", cyc);
        end
        bus_read(0, 2'b00, 8'hA5, "rd_a5");
        bus_read(0, 2'b00, 8'h00, "rd_empty");

        // Fill past capacity
        send_frame(0, 8'h11, 1'b0, 1'b1, 0);
        send_frame(0, 8'h22, 1'b0, 1'b1, 0);
        send_frame(0, 8'h33, 1'b0, 1'b1, 0);
        send_frame(0, 8'h44, 1'b0, 1'b1, 0);
        send_frame(0, 8'h55, 1'b0, 1'b1, 0);
        bus_read(0, 2'b01, 8'h13, "stat_full_ovr");
        bus_read(0, 2'b00, 8'h11, "rd_11");
        bus_read(0, 2'b00, 8'h22, "rd_22");
        bus_read(0, 2'b00, 8'h33, "rd_33");
        bus_read(0, 2'b00, 8'h44, "rd_44");
        bus_read(0, 2'b01, 8'h00, "stat_drained");

        // False start: 4-tick low glitch
        rxd_v[0] = 1'b0;
        repeat (16) @(posedge clk);
        #1 rxd_v[0] = 1'b1;
        repeat (2 * BIT_CYC) @(posedge clk);
        #1;
        bus_read(0, 2'b01, 8'h00, "stat_false_start");
        send_frame(0, 8'h6B, 1'b0, 1'b1, 0);
        bus_read(0, 2'b00, 8'h6B, "rd_6b");

        // Framing error followed by a held-low line
        send_frame(0, 8'h3C, 1'b0, 1'b0, 3);
        bus_read(0, 2'b01, 8'h04, "stat_frame");
        bus_read(0, 2'b00, 8'h00, "rd_after_frame");
        send_frame(0, 8'h81, 1'b0, 1'b1, 0);
        bus_read(0, 2'b00, 8'h81, "rd_81");

        // Even parity instance
        send_frame(1, 8'h07, 1'b0, 1'b1, 0);
        bus_read(1, 2'b01, 8'h08, "stat_parity");
        send_frame(1, 8'h07, 1'b1, 1'b1, 0);
        bus_read(1, 2'b00, 8'h07, "rd_par_07");
        bus_read(1, 2'b01, 8'h00, "stat_par_clean");

        // Reset in the middle of a character with a stored entry
        send_frame(0, 8'h99, 1'b0, 1'b1, 0);
        chk_en = 2'b00;
        drive_bit(0, 1'b0);
        drive_bit(0, 1'b1);
        drive_bit(0, 1'b0);
        rxd_v[0] = 1'b0;
        repeat (20) @(posedge clk);
        #1 rst = 1'b1;
        rxd_v[0] = 1'b1;
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        q0.delete();
        q1.delete();
        m_fe = 2'b00;
        m_ov = 2'b00;
        m_pe = 2'b00;
        chk_en = 2'b11;
        repeat (BIT_CYC) @(posedge clk);
        #1;
        bus_read(0, 2'b01, 8'h00, "stat_after_rst");
        send_frame(0, 8'h5A, 1'b0, 1'b1, 0);
        bus_read(0, 2'b00, 8'h5A, "rd_5a");
        bus_read(0, 2'b01, 8'h00, "stat_final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
